// File: rtl/fpu_cmd_sequencer.sv
// Command FIFO and issue sequencer in front of a start/done floating-point ALU.
// Define FPU_SEQ_TIMEOUT_EN to enable the WAIT-state watchdog (alu_clr, rsp_err).
module fpu_cmd_sequencer #(
   parameter int DEPTH          = 4,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       cmd_valid,
   output logic                       cmd_ready,
   input  logic [31:0]                cmd_a,
   input  logic [31:0]                cmd_b,
   input  logic [2:0]                 cmd_op,
   output logic                       rsp_valid,
   input  logic                       rsp_ready,
   output logic [31:0]                rsp_data,
   output logic                       rsp_err,
   output logic [31:0]                alu_inp1,
   output logic [31:0]                alu_inp2,
   output logic [2:0]                 alu_opt,
   output logic                       alu_start,
   output logic                       alu_clr,
   input  logic [31:0]                alu_out,
   input  logic                       alu_done,
   output logic                       busy,
   output logic [$clog2(DEPTH):0]     fifo_count
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

   typedef struct packed {
      logic [31:0] a;
      logic [31:0] b;
      logic [2:0]  op;
   } cmd_t;

   state_t        state;
   cmd_t          mem [DEPTH];
   cmd_t          head;
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   count;
   logic          push;
   logic          pop;
   logic          armed;

   assign cmd_ready  = (count != FULL);
   assign push       = cmd_valid & cmd_ready;
   assign pop        = (state == IDLE) && (count != '0);
   assign head       = mem[rd_ptr];
   assign busy       = (state != IDLE);
   assign fifo_count = count;

   // NOTE: storage array has no reset; only pointers and count define validity.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= '{a: cmd_a, b: cmd_b, op: cmd_op};
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         unique case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

`ifdef FPU_SEQ_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);
   logic [TW-1:0] wd_cnt;
`else
   assign alu_clr = 1'b0;
   assign rsp_err = 1'b0;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         alu_inp1  <= '0;
         alu_inp2  <= '0;
         alu_opt   <= '0;
         alu_start <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_data  <= '0;
         armed     <= 1'b0;
`ifdef FPU_SEQ_TIMEOUT_EN
         alu_clr   <= 1'b0;
         rsp_err   <= 1'b0;
         wd_cnt    <= '0;
`endif
      end else begin
         // NOTE: pulse outputs default low each cycle; a later assignment in the case wins.
         alu_start <= 1'b0;
`ifdef FPU_SEQ_TIMEOUT_EN
         alu_clr   <= 1'b0;
`endif
         unique case (state)
            IDLE: begin
               if (count != '0) begin
                  alu_inp1  <= head.a;
                  alu_inp2  <= head.b;
                  alu_opt   <= head.op;
                  alu_start <= 1'b1;
                  state     <= ISSUE;
               end
            end
            ISSUE: begin
               armed <= 1'b0;
               state <= WAIT;
`ifdef FPU_SEQ_TIMEOUT_EN
               wd_cnt <= '0;
`endif
            end
            WAIT: begin
               // A done level left over from the previous op must drop before it counts.
               if (!alu_done) armed <= 1'b1;
               if (alu_done && armed) begin
                  rsp_data  <= alu_out;
                  rsp_valid <= 1'b1;
                  state     <= RESP;
`ifdef FPU_SEQ_TIMEOUT_EN
                  rsp_err   <= 1'b0;
               end else if (wd_cnt == TO_LAST) begin
                  alu_clr   <= 1'b1;
                  rsp_data  <= 32'h7FC0_0000;
                  rsp_err   <= 1'b1;
                  rsp_valid <= 1'b1;
                  state     <= RESP;
               end else begin
                  wd_cnt <= wd_cnt + 1'b1;
`endif
               end
            end
            RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fpu_cmd_sequencer.sv
// Directed self-checking bench for fpu_cmd_sequencer with a behavioural start/done ALU.
// Timeout scenario is compiled in when FPU_SEQ_TIMEOUT_EN is defined.
module tb_fpu_cmd_sequencer;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [31:0] cmd_a;
   logic [31:0] cmd_b;
   logic [2:0]  cmd_op;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_data;
   logic        rsp_err;
   logic [31:0] alu_inp1;
   logic [31:0] alu_inp2;
   logic [2:0]  alu_opt;
   logic        alu_start;
   logic        alu_clr;
   logic [31:0] alu_out;
   logic        alu_done;
   logic        busy;
   logic [2:0]  fifo_count;

   int checks   = 0;
   int failures = 0;

   // ALU model controls: mode 0 = done pulse, 1 = done held level, 2 = never done
   int alu_mode = 0;
   int alu_lat  = 6;
   int acnt;
   int drop;
   bit running;

   fpu_cmd_sequencer #(.DEPTH(DEPTH), .TIMEOUT_CYCLES(16)) dut (
      .clk(clk), .reset(reset),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_data(rsp_data), .rsp_err(rsp_err),
      .alu_inp1(alu_inp1), .alu_inp2(alu_inp2), .alu_opt(alu_opt),
      .alu_start(alu_start), .alu_clr(alu_clr),
      .alu_out(alu_out), .alu_done(alu_done),
      .busy(busy), .fifo_count(fifo_count)
   );

   always #5 clk = ~clk;

   // Known IEEE results for the directed float vectors; other vectors get a scrambled word.
   function automatic logic [31:0] alu_fn(logic [31:0] a, logic [31:0] b, logic [2:0] op);
      if (op == 3'd0 && a == 32'h3F80_0000 && b == 32'h4000_0000) return 32'h4040_0000;
      if (op == 3'd1 && a == 32'h4008_0EBF && b == 32'h40AD_999A) return 32'hC053_2475;
      return a ^ {b[15:0], b[31:16]} ^ {29'd0, op};
   endfunction

   // Operands are read at completion time, so late-sampling stability is exercised.
   always @(posedge clk or posedge reset) begin
      if (reset) begin
         alu_done <= 1'b0;
         alu_out  <= '0;
         running  <= 1'b0;
         acnt     <= 0;
         drop     <= 0;
      end else if (alu_clr) begin
         running  <= 1'b0;
         alu_done <= 1'b0;
      end else if (alu_start) begin
         running <= 1'b1;
         acnt    <= alu_lat;
         if (alu_mode == 1 && alu_done) drop <= 2;
         else alu_done <= 1'b0;
      end else begin
         if (drop == 1) alu_done <= 1'b0;
         if (drop > 0) drop <= drop - 1;
         if (running) begin
            acnt <= acnt - 1;
            if (acnt == 1) begin
               running <= 1'b0;
               if (alu_mode != 2) begin
                  alu_done <= 1'b1;
                  alu_out  <= alu_fn(alu_inp1, alu_inp2, alu_opt);
               end
            end
         end else if (alu_mode == 0) begin
            alu_done <= 1'b0;
         end
      end
   end

   task automatic push(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                       output bit ok);
      int n = 0;
      @(negedge clk);
      cmd_valid = 1'b1; cmd_a = a; cmd_b = b; cmd_op = op;
      while (!cmd_ready && n < 200) begin @(negedge clk); n++; end
      ok = cmd_ready;
      if (ok) @(posedge clk);
      #1 cmd_valid = 1'b0;
   endtask

   task automatic get_rsp(output logic [31:0] data, output logic err, output bit ok);
      int n = 0;
      @(negedge clk);
      rsp_ready = 1'b1;
      while (!rsp_valid && n < 300) begin @(negedge clk); n++; end
      ok = rsp_valid; data = rsp_data; err = rsp_err;
      if (ok) begin @(posedge clk); #1; end
   endtask

   task automatic wait_start(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(posedge clk); #1;
         if (alu_start) begin ok = 1'b1; break; end
      end
   endtask

   task automatic test_reset();
      checks++;
      if ({cmd_ready, rsp_valid, busy, alu_start, alu_clr, rsp_err} !== 6'b100000) begin
         failures++;
         $display("FAIL reset_ctrl: got %b expected 100000", {cmd_ready, rsp_valid, busy, alu_start, alu_clr, rsp_err});
      end
      checks++;
      if ({fifo_count, rsp_data, alu_inp1, alu_inp2, alu_opt} !== '0) begin
         failures++;
         $display("FAIL reset_data: count=%0d rsp=%h inp1=%h inp2=%h opt=%0d expected all 0",
                  fifo_count, rsp_data, alu_inp1, alu_inp2, alu_opt);
      end
      @(negedge clk) reset = 1'b0;
   endtask

   task automatic test_single_add();
      logic [31:0] d; logic e; bit ok; int highs = 0; logic [2:0] seq;
      @(negedge clk);
      cmd_valid = 1'b1; cmd_a = 32'h3F80_0000; cmd_b = 32'h4000_0000; cmd_op = 3'd0;
      @(posedge clk); #1 cmd_valid = 1'b0;
      seq[0] = alu_start;
      checks++;
      if (fifo_count !== 3'd1) begin
         failures++; $display("FAIL add_count: got %0d expected 1", fifo_count);
      end
      @(posedge clk); #1 seq[1] = alu_start;
      @(posedge clk); #1 seq[2] = alu_start;
      checks++;
      if (seq !== 3'b010) begin
         failures++; $display("FAIL add_start_timing: got %b expected 010", seq);
      end
      for (int i = 0; i < 20 && !rsp_valid; i++) begin
         @(posedge clk); #1 if (alu_start) highs++;
      end
      checks++;
      if (highs != 0) begin
         failures++; $display("FAIL add_start_once: extra pulses %0d expected 0", highs);
      end
      get_rsp(d, e, ok);
      checks++;
      if (!ok || d !== 32'h4040_0000 || e !== 1'b0) begin
         failures++; $display("FAIL add_rsp: ok=%0b data=%h err=%b expected 40400000 err 0", ok, d, e);
      end
   endtask

   task automatic test_sub_passthrough();
      logic [31:0] d; logic e; bit ok; bit st; bit stable = 1'b1;
      push(32'h4008_0EBF, 32'h40AD_999A, 3'd1, ok);
      wait_start(st);
      checks++;
      if (!st || alu_opt !== 3'd1) begin
         failures++; $display("FAIL sub_opt: started=%0b opt=%0d expected 1", st, alu_opt);
      end
      for (int i = 0; i < 50 && !rsp_valid; i++) begin
         @(posedge clk); #1;
         if (alu_inp1 !== 32'h4008_0EBF || alu_inp2 !== 32'h40AD_999A || alu_opt !== 3'd1) stable = 1'b0;
      end
      checks++;
      if (!stable) begin
         failures++; $display("FAIL sub_stable: operands changed during WAIT, got %h %h %0d", alu_inp1, alu_inp2, alu_opt);
      end
      get_rsp(d, e, ok);
      checks++;
      if (!ok || d !== 32'hC053_2475 || e !== 1'b0) begin
         failures++; $display("FAIL sub_rsp: ok=%0b data=%h err=%b expected c0532475 err 0", ok, d, e);
      end
   endtask

   task automatic test_fifo_full();
      logic [31:0] exp_q[$]; logic [31:0] d, a, b; logic e; bit ok, acc; int accepted = 0;
      bit full_ok = 1'b1;
      rsp_ready = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         a = 32'h4100_0000 + 32'(i * 3); b = 32'h3E00_0000 + 32'(i * 7);
         cmd_valid = 1'b1; cmd_a = a; cmd_b = b; cmd_op = 3'(i + 2);
         acc = cmd_ready;
         @(posedge clk);
         if (acc) begin accepted++; exp_q.push_back(alu_fn(a, b, 3'(i + 2))); end
      end
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         if (cmd_ready !== 1'b0 || fifo_count !== 3'd4) full_ok = 1'b0;
      end
      cmd_valid = 1'b0;
      checks++;
      if (accepted != 5) begin
         failures++; $display("FAIL fifo_accepted: got %0d expected 5", accepted);
      end
      checks++;
      if (!full_ok) begin
         failures++; $display("FAIL fifo_full: ready=%b count=%0d expected ready 0 count 4", cmd_ready, fifo_count);
      end
      for (int i = 0; i < 5; i++) begin
         get_rsp(d, e, ok);
         checks++;
         if (!ok || exp_q.size() == 0 || d !== exp_q[0] || e !== 1'b0) begin
            failures++;
            $display("FAIL fifo_order[%0d]: ok=%0b data=%h expected %h", i, ok, d, exp_q.size() ? exp_q[0] : 32'h0);
         end
         if (exp_q.size() != 0) void'(exp_q.pop_front());
         if (i < 4) begin
            @(posedge clk); #1;
            checks++;
            if (alu_start !== 1'b1) begin
               failures++; $display("FAIL back_to_back[%0d]: alu_start=%b expected 1", i, alu_start);
            end
         end
      end
   endtask

   task automatic test_held_done();
      logic [31:0] d; logic e; bit ok, st; bit seen_low = 1'b0; int first = -1;
      alu_mode = 1;
      push(32'h1111_0000, 32'h0000_2222, 3'd5, ok);
      get_rsp(d, e, ok);
      rsp_ready = 1'b0;
      push(32'h3333_0000, 32'h0000_4444, 3'd6, ok);
      wait_start(st);
      for (int k = 1; k <= 30 && first < 0; k++) begin
         @(posedge clk); #1;
         if (!alu_done) seen_low = 1'b1;
         if (rsp_valid) first = k;
      end
      checks++;
      if (!st || first != 8 || !seen_low) begin
         failures++; $display("FAIL held_done: done at edge %0d low_seen=%0b expected 8 1", first, seen_low);
      end
      get_rsp(d, e, ok);
      checks++;
      if (!ok || d !== alu_fn(32'h3333_0000, 32'h0000_4444, 3'd6)) begin
         failures++; $display("FAIL held_rsp: got %h expected %h", d, alu_fn(32'h3333_0000, 32'h0000_4444, 3'd6));
      end
      alu_mode = 0;
      repeat (2) @(posedge clk);
   endtask

   task automatic test_reset_mid_wait();
      bit ok, st; bit stale = 1'b0;
      alu_lat = 20;
      rsp_ready = 1'b1;
      push(32'h5555_0000, 32'h0000_6666, 3'd0, ok);
      wait_start(st);
      push(32'h7777_0000, 32'h0000_8888, 3'd1, ok);
      push(32'h9999_0000, 32'h0000_AAAA, 3'd2, ok);
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (fifo_count !== 3'd2 || busy !== 1'b1) begin
         failures++; $display("FAIL rst_pre: count=%0d busy=%b expected 2 1", fifo_count, busy);
      end
      @(negedge clk);
      #1 reset = 1'b1;
      #1;
      checks++;
      if ({busy, fifo_count, rsp_valid, alu_start} !== 6'b0) begin
         failures++;
         $display("FAIL rst_async: busy=%b count=%0d rsp_valid=%b start=%b expected all 0", busy, fifo_count, rsp_valid, alu_start);
      end
      @(negedge clk) reset = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (rsp_valid || busy) stale = 1'b1;
      end
      checks++;
      if (stale) begin
         failures++; $display("FAIL rst_stale: activity after reset, rsp_valid=%b busy=%b expected 0", rsp_valid, busy);
      end
      alu_lat = 6;
   endtask

`ifdef FPU_SEQ_TIMEOUT_EN
   task automatic test_timeout();
      logic [31:0] d; logic e; bit ok, st; int clr_n = 0; int clr_at = -1;
      alu_mode = 2;
      rsp_ready = 1'b0;
      push(32'hAAAA_0000, 32'h0000_BBBB, 3'd7, ok);
      wait_start(st);
      push(32'hCCCC_0000, 32'h0000_DDDD, 3'd3, ok);
      for (int k = 2; k <= 30; k++) begin
         @(posedge clk); #1;
         if (alu_clr) begin clr_n++; clr_at = k; end
      end
      alu_mode = 0;
      checks++;
      if (!st || clr_n != 1 || clr_at != 17) begin
         failures++; $display("FAIL timeout_clr: pulses=%0d at edge %0d expected 1 at 17", clr_n, clr_at);
      end
      get_rsp(d, e, ok);
      checks++;
      if (!ok || d !== 32'h7FC0_0000 || e !== 1'b1) begin
         failures++; $display("FAIL timeout_rsp: data=%h err=%b expected 7fc00000 err 1", d, e);
      end
      get_rsp(d, e, ok);
      checks++;
      if (!ok || d !== alu_fn(32'hCCCC_0000, 32'h0000_DDDD, 3'd3) || e !== 1'b0) begin
         failures++; $display("FAIL timeout_next: data=%h err=%b expected %h err 0", d, e, alu_fn(32'hCCCC_0000, 32'h0000_DDDD, 3'd3));
      end
   endtask
`else
   task automatic test_no_timeout();
      bit ok, st; bit any = 1'b0;
      alu_mode = 2;
      rsp_ready = 1'b1;
      push(32'hAAAA_0000, 32'h0000_BBBB, 3'd7, ok);
      wait_start(st);
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (alu_clr || rsp_valid || rsp_err || !busy) any = 1'b1;
      end
      checks++;
      if (!st || any) begin
         failures++; $display("FAIL no_timeout: started=%0b left WAIT or pulsed clr, expected to wait", st);
      end
      alu_mode = 0;
      @(negedge clk) reset = 1'b1;
      @(negedge clk) reset = 1'b0;
   endtask
`endif

   initial begin
      reset = 1'b1; cmd_valid = 1'b0; cmd_a = '0; cmd_b = '0; cmd_op = '0; rsp_ready = 1'b0;
      #12;
      test_reset();
      test_single_add();
      test_sub_passthrough();
      test_fifo_full();
      test_held_done();
      test_reset_mid_wait();
`ifdef FPU_SEQ_TIMEOUT_EN
      test_timeout();
`else
      test_no_timeout();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/fpu_cmd_sequencer.md
# fpu_cmd_sequencer

Command front-end for the `floating_alu` start/done engine. It accepts IEEE-754 single-precision add/subtract commands over a valid/ready port and buffers them in a small FIFO. It issues the commands one at a time to the ALU, driving the operands, the opcode and a start pulse, then waits for done. Each captured ALU result is returned on a valid/ready response port, so upstream logic can stream operations without tracking the ALU's multi-cycle FSM.

## Interface
- `DEPTH`, 4: command FIFO entries; power of two, at least 2.
- `TIMEOUT_CYCLES`, 64: WAIT-state watchdog limit. Used only when `FPU_SEQ_TIMEOUT_EN` is defined.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `cmd_valid` in 1: command offered.
- `cmd_ready` out 1: equals `~fifo_full`.
- `cmd_a` in 32: operand 1, IEEE-754 single precision.
- `cmd_b` in 32: operand 2, IEEE-754 single precision.
- `cmd_op` in 3: ALU opcode, passed through unchanged (0 = add, 1 = subtract).
- `rsp_valid` out 1: result available.
- `rsp_ready` in 1: downstream accepts the result.
- `rsp_data` out 32: result word.
- `rsp_err` out 1: result was produced by a timeout.
- `alu_inp1`, `alu_inp2` out 32: operands to the ALU.
- `alu_opt` out 3: opcode to the ALU.
- `alu_start` out 1: one-cycle issue pulse.
- `alu_clr` out 1: one-cycle ALU reset pulse on timeout.
- `alu_out` in 32: ALU result.
- `alu_done` in 1: ALU completion; may be a pulse or a held level.
- `busy` out 1: high when the FSM is not in IDLE.
- `fifo_count` out log2(DEPTH)+1: number of queued commands.

## Operation
- FIFO behaviour:
  - A push occurs on `cmd_valid & cmd_ready`. A pop occurs when IDLE leaves with a non-empty FIFO.
  - A simultaneous push and pop leaves the count unchanged.
  - Read and write pointers wrap modulo DEPTH.
  - There is no bypass: a command always passes through the FIFO.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If the FIFO is non-empty: load `alu_inp1`/`alu_inp2`/`alu_opt` from the head entry, pop it, and go to ISSUE.
  - Otherwise stay in IDLE.
- ISSUE:
  - `alu_start` = 1 for exactly this cycle.
  - Clear the `armed` flag and go to WAIT.
  - `alu_done` is ignored in this state.
- WAIT:
  - `armed` is set on the first cycle in which `alu_done` = 0.
  - The state completes only on `alu_done & armed`. This rejects a done level still held from the previous operation.
  - On completion: capture `alu_out` into `rsp_data`, set `rsp_err` = 0, go to RESP.
- RESP:
  - `rsp_valid` = 1.
  - `rsp_data` and `rsp_err` stay stable until `rsp_ready`, then go to IDLE.
- Operand registers stay stable from the end of IDLE until the next IDLE exit. This covers any ALU that samples its operands late.
- Opcodes are not interpreted; any of the 8 values is forwarded unchanged.
- Mid-operation reset (`reset` asserted in any state):
  - FSM goes to IDLE and the FIFO empties.
  - The in-flight result is discarded.
  - `alu_start` drops asynchronously.
- Reset value of every output: 0, except `cmd_ready`, which is 1 because the FIFO is empty.

## Timing
- Edge E0: push into an empty FIFO.
- Edge E1: IDLE exits. `alu_start` is high during cycle E1–E2.
- Edge E2: enter WAIT.
- Edge Ed: first edge at which `alu_done & armed` is sampled high. `rsp_valid` is high from Ed.
- Minimum command-to-response latency is therefore 3 edges plus the ALU latency.
- Back-to-back commands: the next IDLE exit happens 1 edge after the `rsp_ready` handshake.
- Peak throughput is one result per (ALU latency + 4) cycles.
- `rsp_valid` never depends combinationally on `rsp_ready`.
- `cmd_ready` depends only on registered state.

## Configuration
- `FPU_SEQ_TIMEOUT_EN` defined:
  - A counter clears on entry to WAIT and increments every cycle spent in WAIT.
  - When the counter reaches `TIMEOUT_CYCLES` without completion:
    - `alu_clr` is 1 for one cycle.
    - `rsp_data` = 32'h7FC00000 (quiet NaN) and `rsp_err` = 1.
    - The FSM goes to RESP.
  - Completion on the same cycle as the timeout takes priority: normal result, `rsp_err` = 0.
- `FPU_SEQ_TIMEOUT_EN` undefined:
  - WAIT waits forever; there is no counter.
  - `alu_clr` and `rsp_err` are tied to 0. Both ports remain present.

## Test plan
- **Single add:** after reset, push `cmd_a`=32'h3F800000 (1.0), `cmd_b`=32'h40000000 (2.0), op=0, using a behavioural ALU with 6-cycle latency. Require:
  - `alu_start` high for 1 cycle, 2 edges after the push.
  - `rsp_data`=32'h40400000 (3.0) and `rsp_err`=0.
- **Subtract pass-through:** push `cmd_a`=32'h40080EBF, `cmd_b`=32'h40AD999A, op=1. Require `alu_opt`=1 and the operands held stable through WAIT, and `rsp_data` equal to the model output.
- **FIFO full with stalled response:**
  - With DEPTH=4 and `rsp_ready`=0, push 6 commands. Require `cmd_ready`=0 once `fifo_count`=4, and no overflow.
  - Release `rsp_ready`. Require all 5 accepted results returned in order.
- **Held-level done:**
  - The ALU model keeps `alu_done` high until the next start and deasserts it 2 cycles late. Require no early completion; completion only after done goes low then high again.
- **Reset mid-WAIT:** assert `reset` during WAIT with 2 commands queued. Require, immediately and asynchronously:
  - `busy`=0, `fifo_count`=0, `rsp_valid`=0.
  - No stale response after reset is released.
- **Timeout (macro defined, `TIMEOUT_CYCLES`=16):** the ALU model never asserts done. Require:
  - `alu_clr` pulses exactly once, 16 cycles after WAIT entry.
  - `rsp_data`=32'h7FC00000 and `rsp_err`=1.
  - The next queued command issues normally afterwards.
